// File: rtl/serial_adder.sv
// serial_adder: multi-cycle ripple adder summing D bits of two N-bit operands
// per clock through a registered carry, with a Start/Busy/Done handshake.
// Optional build macro: SUBTRACT_EN adds the Sub port (Sub=1 computes X-Y).
module serial_adder #(
   parameter int N = 8,
   parameter int D = 1
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         Start,
   input  logic         Cin,
`ifdef SUBTRACT_EN
   input  logic         Sub,
`endif
   input  logic [N-1:0] X,
   input  logic [N-1:0] Y,
   output logic [N-1:0] S,
   output logic         Cout,
   output logic         Overflow,
   output logic         Busy,
   output logic         Done
);

   localparam int NDIG = N / D;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST    = CW'(NDIG - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   generate
      if (N < 2 || (N % D) != 0) begin : g_param_check
         $error("serial_adder: N must be >= 2 and an integer multiple of D");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    xr_q, xr_d;
   logic [N-1:0]    yr_q, yr_d;
   logic [N-1:0]    s_q, s_d;
   logic            carry_q, carry_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [D:0]      digit;
   logic [N+D-1:0]  s_shift;
   logic            accept;
   logic [N-1:0]    y_load;
   logic            c_load;

   // Next-state: operand capture on accepted Start, one digit per RUN cycle.
   always_comb begin
      state_d = state_q;
      xr_d    = xr_q;
      yr_d    = yr_q;
      s_d     = s_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;

      digit   = {1'b0, xr_q[D-1:0]} + {1'b0, yr_q[D-1:0]} + {{D{1'b0}}, carry_q};
      // Concatenate then slice so the shift is legal even when D == N.
      s_shift = {digit[D-1:0], s_q};
      accept  = Start && (state_q == ST_IDLE || state_q == ST_DONE);

`ifdef SUBTRACT_EN
      y_load  = Sub ? ~Y : Y;
      c_load  = Sub | Cin;
`else
      y_load  = Y;
      c_load  = Cin;
`endif

      case (state_q)
         ST_RUN: begin
            xr_d    = xr_q >> D;
            yr_d    = yr_q >> D;
            carry_d = digit[D];
            s_d     = s_shift[N+D-1:D];
            cnt_d   = cnt_q + CNT_ONE;
            if (cnt_q == LAST) begin
               cout_d  = digit[D];
               // Carry into the MSB recovered as x^y^sum at that bit.
               ovf_d   = xr_q[D-1] ^ yr_q[D-1] ^ digit[D-1] ^ digit[D];
               state_d = ST_DONE;
            end
         end
         default: begin
            if (accept) begin
               xr_d    = X;
               yr_d    = y_load;
               carry_d = c_load;
               cnt_d   = '0;
               state_d = ST_RUN;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         xr_q    <= '0;
         yr_q    <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         xr_q    <= xr_d;
         yr_q    <= yr_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign S        = s_q;
   assign Cout     = cout_q;
   assign Overflow = ovf_q;
   assign Busy     = (state_q == ST_RUN);
   assign Done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (N=8 with D=1 and D=4 instances).
// Build with SUBTRACT_EN defined to also exercise the Sub port.
module tb_serial_adder;
   localparam int N    = 8;
   localparam int NCYC = N;      // D=1 instance: digits per operation
   localparam int NCY4 = N / 4;  // D=4 instance

   logic         clk = 1'b0;
   logic         rst;
   logic         start, start4, cin;
   logic [N-1:0] x, y;
`ifdef SUBTRACT_EN
   logic         sub;
`endif
   logic [N-1:0] s, s4;
   logic         cout, ovf, busy, done;
   logic         cout4, ovf4, busy4, done4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   serial_adder #(.N(8), .D(1)) dut (
      .Clock(clk), .Reset(rst), .Start(start), .Cin(cin),
`ifdef SUBTRACT_EN
      .Sub(sub),
`endif
      .X(x), .Y(y), .S(s), .Cout(cout), .Overflow(ovf), .Busy(busy), .Done(done)
   );

   serial_adder #(.N(8), .D(4)) dut4 (
      .Clock(clk), .Reset(rst), .Start(start4), .Cin(cin),
`ifdef SUBTRACT_EN
      .Sub(sub),
`endif
      .X(x), .Y(y), .S(s4), .Cout(cout4), .Overflow(ovf4), .Busy(busy4), .Done(done4)
   );

   // Reference: integer arithmetic, returns {overflow, cout, sum}.
   function automatic logic [N+1:0] model(input int xv, input int yv, input int cv, input int sb);
      int full, sx, sy, sr, md, hf;
      logic [N+1:0] r;
      md = 1 << N;
      hf = 1 << (N - 1);
      sx = (xv >= hf) ? xv - md : xv;
      sy = (yv >= hf) ? yv - md : yv;
      if (sb != 0) begin
         full = xv - yv + md;
         sr   = sx - sy;
      end else begin
         full = xv + yv + cv;
         sr   = sx + sy + cv;
      end
      r[N-1:0] = N'(full % md);
      r[N]     = (full >= md);
      r[N+1]   = (sr >= hf) || (sr < -hf);
      return r;
   endfunction

   task automatic present(input logic [N-1:0] xv, input logic [N-1:0] yv, input logic cv);
      x = xv;
      y = yv;
      cin = cv;
      start = 1'b1;
   endtask

   // Counts edges from the Start-sampling edge (edge 1) until Done; -1 on timeout.
   task automatic wait_done(output int edges, output int busy_cnt);
      edges = -1;
      busy_cnt = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) start = 1'b0;
         if (done) begin
            edges = k;
            return;
         end
         if (busy) busy_cnt++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      start4 = 1'b0;
      cin = 1'b0;
      x = '0;
      y = '0;
`ifdef SUBTRACT_EN
      sub = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({s, cout, ovf, busy, done} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got S=%0d Cout=%b Ovf=%b Busy=%b Done=%b, want all 0", s, cout, ovf, busy, done);
      end
      n_cmp++;
      if ({s4, cout4, ovf4, busy4, done4} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs_d4: got S=%0d Cout=%b Ovf=%b Busy=%b Done=%b, want all 0", s4, cout4, ovf4, busy4, done4);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_add_directed();
      logic [N-1:0] xs[4] = '{8'd100, 8'd200, 8'd100, 8'd255};
      logic [N-1:0] ys[4] = '{8'd27, 8'd100, 8'd50, 8'd0};
      logic         cs[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [N+1:0] exp;
      int edges, bc;
      for (int i = 0; i < 4; i++) begin
         exp = model(int'(xs[i]), int'(ys[i]), int'(cs[i]), 0);
         present(xs[i], ys[i], cs[i]);
         wait_done(edges, bc);
         n_cmp++;
         if (edges !== NCYC + 1) begin
            n_bad++;
            $display("FAIL add_latency[%0d]: got %0d edges, want %0d", i, edges, NCYC + 1);
         end
         n_cmp++;
         if (bc !== NCYC) begin
            n_bad++;
            $display("FAIL add_busy_cycles[%0d]: got %0d, want %0d", i, bc, NCYC);
         end
         n_cmp++;
         if ({ovf, cout, s} !== exp) begin
            n_bad++;
            $display("FAIL add_result[%0d]: got S=%0d Cout=%b Ovf=%b, want S=%0d Cout=%b Ovf=%b",
                     i, s, cout, ovf, exp[N-1:0], exp[N], exp[N+1]);
         end
         // Done is a single-cycle pulse; result holds while inputs wander.
         x = 8'hA5;
         y = 8'h5A;
         cin = ~cin;
         repeat (2) @(posedge clk);
         #1;
         n_cmp++;
         if ({done, busy} !== 2'b00 || {ovf, cout, s} !== exp) begin
            n_bad++;
            $display("FAIL add_hold[%0d]: got Done=%b Busy=%b S=%0d Cout=%b Ovf=%b, want 0 0 S=%0d Cout=%b Ovf=%b",
                     i, done, busy, s, cout, ovf, exp[N-1:0], exp[N], exp[N+1]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [N+1:0] exp;
      int edges, bc;
      exp = model(255, 0, 1, 0);
      present(8'd255, 8'd0, 1'b1);
      wait_done(edges, bc);
      n_cmp++;
      if ({ovf, cout, s} !== exp || edges !== NCYC + 1) begin
         n_bad++;
         $display("FAIL b2b_first: got S=%0d Cout=%b Ovf=%b edges=%0d, want S=%0d Cout=%b Ovf=%b edges=%0d",
                  s, cout, ovf, edges, exp[N-1:0], exp[N], exp[N+1], NCYC + 1);
      end
      // Start asserted during the Done cycle must be accepted.
      exp = model(77, 200, 0, 0);
      present(8'd77, 8'd200, 1'b0);
      wait_done(edges, bc);
      n_cmp++;
      if ({ovf, cout, s} !== exp || edges !== NCYC + 1) begin
         n_bad++;
         $display("FAIL b2b_second: got S=%0d Cout=%b Ovf=%b edges=%0d, want S=%0d Cout=%b Ovf=%b edges=%0d",
                  s, cout, ovf, edges, exp[N-1:0], exp[N], exp[N+1], NCYC + 1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_busy_ignore();
      int edges;
      edges = -1;
      present(8'd10, 8'd20, 1'b0);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) start = 1'b0;
         if (k == 3) present(8'd99, 8'd99, 1'b1);
         if (k == 4) start = 1'b0;
         if (k > 4) x = N'($urandom);
         if (done) begin
            edges = k;
            break;
         end
      end
      n_cmp++;
      if (s !== 8'd30 || edges !== NCYC + 1) begin
         n_bad++;
         $display("FAIL busy_ignore: got S=%0d edges=%0d, want S=30 edges=%0d", s, edges, NCYC + 1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_abort();
      int edges, bc;
      logic seen_done;
      seen_done = 1'b0;
      present(8'd1, 8'd1, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) start = 1'b0;
         if (k == 3) begin
            x = 8'd5;
            start = 1'b1;
         end
         if (k == 4) start = 1'b0;
         if (k == 5) rst = 1'b1;
         if (k == 6) rst = 1'b0;
         if (done) seen_done = 1'b1;
      end
      n_cmp++;
      if ({s, cout, ovf, busy, done} !== '0) begin
         n_bad++;
         $display("FAIL abort_outputs: got S=%0d Cout=%b Ovf=%b Busy=%b Done=%b, want all 0", s, cout, ovf, busy, done);
      end
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done || busy) seen_done = 1'b1;
      end
      n_cmp++;
      if (seen_done !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_no_done: got activity=%b, want 0", seen_done);
      end
      present(8'd3, 8'd4, 1'b0);
      wait_done(edges, bc);
      n_cmp++;
      if (s !== 8'd7 || edges !== NCYC + 1) begin
         n_bad++;
         $display("FAIL abort_restart: got S=%0d edges=%0d, want S=7 edges=%0d", s, edges, NCYC + 1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      logic [N+1:0] exp;
      logic [N-1:0] xv, yv;
      logic         cv;
      int edges, bc;
      for (int i = 0; i < 40; i++) begin
         xv = N'($urandom);
         yv = N'($urandom);
         cv = 1'($urandom);
         exp = model(int'(xv), int'(yv), int'(cv), 0);
         present(xv, yv, cv);
         wait_done(edges, bc);
         n_cmp++;
         if ({ovf, cout, s} !== exp || edges !== NCYC + 1 || bc !== NCYC) begin
            n_bad++;
            $display("FAIL random[%0d] %0d+%0d+%0d: got S=%0d Cout=%b Ovf=%b edges=%0d busy=%0d, want S=%0d Cout=%b Ovf=%b edges=%0d busy=%0d",
                     i, xv, yv, cv, s, cout, ovf, edges, bc, exp[N-1:0], exp[N], exp[N+1], NCYC + 1, NCYC);
         end
         // Sometimes back-to-back (Start in Done cycle), sometimes idle gaps.
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_d4();
      logic [N-1:0] xs[5];
      logic [N-1:0] ys[5];
      logic [N+1:0] exp;
      int edges, bc;
      xs[0] = 8'hF0;
      ys[0] = 8'h10;
      for (int i = 1; i < 5; i++) begin
         xs[i] = N'($urandom);
         ys[i] = N'($urandom);
      end
      cin = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp = model(int'(xs[i]), int'(ys[i]), 0, 0);
         x = xs[i];
         y = ys[i];
         start4 = 1'b1;
         edges = -1;
         bc = 0;
         for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) start4 = 1'b0;
            if (done4) begin
               edges = k;
               break;
            end
            if (busy4) bc++;
         end
         n_cmp++;
         if ({ovf4, cout4, s4} !== exp || edges !== NCY4 + 1 || bc !== NCY4) begin
            n_bad++;
            $display("FAIL d4[%0d] %0d+%0d: got S=%0d Cout=%b Ovf=%b edges=%0d busy=%0d, want S=%0d Cout=%b Ovf=%b edges=%0d busy=%0d",
                     i, xs[i], ys[i], s4, cout4, ovf4, edges, bc, exp[N-1:0], exp[N], exp[N+1], NCY4 + 1, NCY4);
         end
         @(posedge clk);
         #1;
      end
   endtask

`ifdef SUBTRACT_EN
   task automatic test_subtract();
      logic [N-1:0] xs[12];
      logic [N-1:0] ys[12];
      logic [N+1:0] exp;
      int edges, bc;
      xs[0] = 8'd50;  ys[0] = 8'd70;
      xs[1] = 8'd128; ys[1] = 8'd1;
      xs[2] = 8'd5;   ys[2] = 8'd0;
      xs[3] = 8'd0;   ys[3] = 8'd128;
      for (int i = 4; i < 12; i++) begin
         xs[i] = N'($urandom);
         ys[i] = N'($urandom);
      end
      sub = 1'b1;
      for (int i = 0; i < 12; i++) begin
         exp = model(int'(xs[i]), int'(ys[i]), 0, 1);
         // Cin must be ignored when subtracting.
         present(xs[i], ys[i], 1'($urandom));
         wait_done(edges, bc);
         n_cmp++;
         if ({ovf, cout, s} !== exp || edges !== NCYC + 1) begin
            n_bad++;
            $display("FAIL sub[%0d] %0d-%0d: got S=%0d Cout=%b Ovf=%b edges=%0d, want S=%0d Cout=%b Ovf=%b edges=%0d",
                     i, xs[i], ys[i], s, cout, ovf, edges, exp[N-1:0], exp[N], exp[N+1], NCYC + 1);
         end
         @(posedge clk);
         #1;
      end
      sub = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_add_directed();
      test_back_to_back();
      test_busy_ignore();
      test_abort();
      test_random();
      test_d4();
`ifdef SUBTRACT_EN
      test_subtract();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
